atp_gateway_arbiter: RTL and testbench

Shares one payment-gateway authorisation link between `N_REQ` ATP kiosk payment FSMs (card/UPI/cash/DD states). Requesters are served in round-robin order. For each granted requester the block issues one authorisation to the gateway, times out a silent gateway, and returns a pass/fail result. It sits between the per-kiosk controllers and the single gateway interface.

---
 rtl/atp_gateway_arbiter_if.sv | 26 ++
 rtl/atp_gateway_arbiter.sv | 140 ++++++++++++++
 tb/tb_atp_gateway_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/atp_gateway_arbiter_if.sv
// atp_gateway_arbiter_if: kiosk request bus and gateway authorisation handshake
interface atp_gateway_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AMT_W = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*AMT_W-1:0] req_amt;
  logic [N_REQ*2-1:0]     req_mode;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   pass;
  logic                   gw_start;
  logic [AMT_W-1:0]       gw_amt;
  logic [1:0]             gw_mode;
  logic                   gw_resp_valid;
  logic                   gw_resp_ok;
  logic                   busy;
  modport master (
    output req, req_amt, req_mode, gw_resp_valid, gw_resp_ok,
    input  grant, done, pass, gw_start, gw_amt, gw_mode, busy
  );
  modport slave (
    input  req, req_amt, req_mode, gw_resp_valid, gw_resp_ok,
    output grant, done, pass, gw_start, gw_amt, gw_mode, busy
  );
endinterface

// File: rtl/atp_gateway_arbiter.sv
// atp_gateway_arbiter: round-robin owner of one gateway link with timeout; define ATP_GW_RETRY_EN to retry once on timeout
module atp_gateway_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AMT_W   = 16,
  parameter int TIMEOUT = 200
) (
  input logic                  clk,
  input logic                  rst,
  atp_gateway_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    own_q, own_d, rr_q, rr_d, pick;
  logic             found;
  logic [AMT_W-1:0] amt_q, amt_d, gw_amt_q, gw_amt_d;
  logic [1:0]       mode_q, mode_d, gw_mode_q, gw_mode_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic             pass_q, pass_d, start_q, start_d, busy_q;
`ifdef ATP_GW_RETRY_EN
  logic             retry_q, retry_d;
`endif
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && bus.req[(int'(rr_q) + i) % N_REQ]) begin
        pick  = IW'((int'(rr_q) + i) % N_REQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    rr_d      = rr_q;
    amt_d     = amt_q;
    mode_d    = mode_q;
    gw_amt_d  = gw_amt_q;
    gw_mode_d = gw_mode_q;
    tmr_d     = tmr_q;
    grant_d   = grant_q;
    done_d    = '0;
    pass_d    = 1'b0;
    start_d   = 1'b0;
`ifdef ATP_GW_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: state_d = |bus.req ? ARB : IDLE;
      ARB: begin
        own_d   = pick;
        amt_d   = bus.req_amt[int'(pick) * AMT_W +: AMT_W];
        mode_d  = bus.req_mode[int'(pick) * 2 +: 2];
        grant_d = found ? N_REQ'(1) << pick : '0;
        state_d = found ? ISSUE : IDLE;
`ifdef ATP_GW_RETRY_EN
        retry_d = 1'b0;
`endif
      end
      ISSUE: begin
        // a zero amount needs no authorisation and passes immediately
        state_d   = amt_q == '0 ? RESP : WAIT;
        done_d    = amt_q == '0 ? grant_q : '0;
        pass_d    = amt_q == '0;
        start_d   = amt_q != '0;
        tmr_d     = '0;
        gw_amt_d  = amt_q;
        gw_mode_d = mode_q;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (bus.gw_resp_valid) begin
          state_d = RESP;
          done_d  = grant_q;
          pass_d  = bus.gw_resp_ok;
        end else if (tmr_q == 16'(TIMEOUT)) begin
`ifdef ATP_GW_RETRY_EN
          state_d = retry_q ? RESP : ISSUE;
          done_d  = retry_q ? grant_q : '0;
          retry_d = 1'b1;
`else
          state_d = RESP;
          done_d  = grant_q;
`endif
        end
      end
      RESP: begin
        grant_d = '0;
        rr_d    = own_q == IW'(N_REQ - 1) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_q     <= '0;
      rr_q      <= '0;
      amt_q     <= '0;
      mode_q    <= '0;
      gw_amt_q  <= '0;
      gw_mode_q <= '0;
      tmr_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      pass_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ATP_GW_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      rr_q      <= rr_d;
      amt_q     <= amt_d;
      mode_q    <= mode_d;
      gw_amt_q  <= gw_amt_d;
      gw_mode_q <= gw_mode_d;
      tmr_q     <= tmr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      start_q   <= start_d;
      busy_q    <= state_d != IDLE;
`ifdef ATP_GW_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end
  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.gw_start = start_q;
  assign bus.gw_amt   = gw_amt_q;
  assign bus.gw_mode  = gw_mode_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_atp_gateway_arbiter.sv
// tb_atp_gateway_arbiter: random kiosk traffic checked against a transaction-level round-robin/timeout model
module tb_atp_gateway_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int T  = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  atp_gateway_arbiter_if #(.N_REQ(N), .AMT_W(AW)) bus ();
  atp_gateway_arbiter #(.N_REQ(N), .AMT_W(AW), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  int rr = 0;
  bit abort = 1'b0;
  logic [AW-1:0] amt [N];
  logic [1:0]    mode [N];
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask
  task automatic check_reset();
    check("rst_grant", bus.grant, '0);
    check("rst_done", bus.done, '0);
    check("rst_pass", bus.pass, 0);
    check("rst_start", bus.gw_start, 0);
    check("rst_amt", bus.gw_amt, '0);
    check("rst_mode", bus.gw_mode, '0);
    check("rst_busy", bus.busy, 0);
  endtask
  task automatic set_kiosk(int i, logic [AW-1:0] a, logic [1:0] m);
    amt[i] = a;
    mode[i] = m;
    bus.req_amt[i*AW +: AW] = a;
    bus.req_mode[i*2 +: 2] = m;
    bus.req[i] = 1'b1;
  endtask
  task automatic raise(logic [N-1:0] m, bit allow_zero);
    for (int i = 0; i < N; i++)
      if (m[i] && !bus.req[i])
        set_kiosk(i, (allow_zero && $urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 65535)), 2'($urandom));
  endtask
  // gateway answers d cycles after the first gw_start unless silent
  task automatic run_txn(int d, bit silent, bit ok, bit chk_lat, bit stray, bit mid);
    int own, k, r, dn;
    bit zero, hit, p, retry, es;
    logic [N-1:0] oh;
`ifdef ATP_GW_RETRY_EN
    retry = 1'b1;
`else
    retry = 1'b0;
`endif
    own = -1;
    for (int i = 0; i < N; i++)
      if (own < 0 && bus.req[(rr + i) % N]) own = (rr + i) % N;
    if (own < 0) own = rr;
    oh = N'(1) << own;
    k = 0;
    do begin
      @(negedge clk);
      bus.gw_resp_valid = 1'b0;
      k++;
    end while (bus.grant == '0 && k < 8);
    check("grant", bus.grant, oh);
    if (bus.grant == '0) begin
      abort = 1'b1;
      return;
    end
    if (chk_lat) check("grant_lat", k, 2);
    check("busy_issue", bus.busy, 1);
    zero = amt[own] == '0;
    r = 1 + d;
    hit = !zero && !silent && (r <= T + 1 || (retry && r >= T + 3 && r <= 2*T + 3));
    dn = zero ? 1 : hit ? r + 1 : retry ? 2*T + 4 : T + 2;
    p = zero || (hit && ok);
    bus.gw_resp_valid = stray;
    bus.gw_resp_ok = 1'b1;
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      es = !zero && (c == 1 || (retry && c == T + 3 && dn > T + 2));
      check("gw_start", bus.gw_start, es);
      if (es) begin
        check("gw_amt", bus.gw_amt, amt[own]);
        check("gw_mode", bus.gw_mode, mode[own]);
      end
      check("done", bus.done, c == dn ? oh : '0);
      check("busy", bus.busy, c <= dn);
      if (c == dn) begin
        check("pass", bus.pass, p);
        check("grant_hold", bus.grant, oh);
        bus.req[own] = 1'b0;
      end
      if (c == dn + 1) check("grant_clr", bus.grant, '0);
      if (c == 1 && mid) begin
        bus.req[own] = 1'b0;
        raise(N'($urandom) & ~oh, 1'b1);
      end
      bus.gw_resp_valid = !silent && c == r;
      bus.gw_resp_ok = ok;
    end
    rr = (own + 1) % N;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req = '0;
    bus.req_amt = '0;
    bus.req_mode = '0;
    bus.gw_resp_valid = 1'b0;
    bus.gw_resp_ok = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b1;
    @(negedge clk);
    set_kiosk(0, 16'd500, 2'b01);
    run_txn(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_kiosk(0, 16'd77, 2'b10);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    bus.gw_resp_valid = 1'b1;
    bus.gw_resp_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.gw_resp_valid = 1'b0;
      check("late_done", bus.done, '0);
      check("late_busy", bus.busy, 0);
    end
    rr = 0;
    raise('1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      run_txn(int'($urandom_range(0, T)), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      raise('1, 1'b0);
    end
    bus.req = '0;
    set_kiosk(3, 16'd1234, 2'b11);
    run_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    set_kiosk(2, 16'd0, 2'b00);
    run_txn(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    set_kiosk(1, 16'd99, 2'b00);
    run_txn(T, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_kiosk(1, 16'd99, 2'b00);
    run_txn(T, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.gw_resp_valid = 1'b1;
    bus.gw_resp_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_done", bus.done, '0);
      check("stray_busy", bus.busy, 0);
    end
    bus.gw_resp_valid = 1'b0;
    for (int n = 0; n < 40 && !abort; n++) begin
      if (bus.req == '0) raise(N'($urandom_range(1, (1 << N) - 1)), 1'b1);
      run_txn(int'($urandom_range(0, 2*T + 4)), $urandom_range(0, 3) == 0, 1'($urandom),
              1'b0, 1'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
